// File: rtl/sr_transfer_ctrl.sv
// Sequencer that drives two universal shift registers (A and B) through
// load, move, swap and copy transfers. Optional macro: SR_CTRL_ROTATE_EN.
module sr_transfer_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear_b,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             sout_a,
   input  logic             sout_b,
   input  logic [WIDTH-1:0] pout_a,
   output logic [1:0]       s_a,
   output logic [1:0]       s_b,
   output logic             sin_r_a,
   output logic             sin_r_b,
   output logic [WIDTH-1:0] pin_b,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] OP_LOAD_A   = 2'b00;
   localparam logic [1:0] OP_MOVE_A2B = 2'b01;
   localparam logic [1:0] OP_SWAP     = 2'b10;
   localparam logic [1:0] OP_COPY_A2B = 2'b11;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_SHR   = 2'b01;
   localparam logic [1:0] MODE_PLOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ONE   = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t          state_r;
   state_t          next_state_s;
   logic [CW-1:0]   count_r;
   logic [1:0]      op_r;
   logic            shift_op_s;

   // MOVE and SWAP are the multi-cycle serial transfers
   assign shift_op_s = op[1] ^ op[0];

   // State, shift counter and captured opcode
   always_ff @(posedge clk or posedge clear_b) begin
      if (clear_b) begin
         state_r <= IDLE;
         count_r <= {CW{1'b0}};
         op_r    <= OP_LOAD_A;
      end else begin
         state_r <= next_state_s;
         case (state_r)
            IDLE: begin
               if (start) begin
                  op_r <= op;
                  if (shift_op_s) begin
                     count_r <= CW'(WIDTH - 1);
                  end
               end
            end
            SHIFT: begin
               if (count_r != {CW{1'b0}}) begin
                  count_r <= count_r - CW'(1);
               end
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Next-state logic and register control decode
   always_comb begin
      next_state_s = state_r;
      s_a          = MODE_HOLD;
      s_b          = MODE_HOLD;
      sin_r_a      = 1'b0;
      sin_r_b      = 1'b0;
      pin_b        = {WIDTH{1'b0}};
      busy         = 1'b1;
      done         = 1'b0;
      case (state_r)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               next_state_s = shift_op_s ? SHIFT : ONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         ONE: begin
            next_state_s = DONE;
            if (op_r == OP_COPY_A2B) begin
               s_b   = MODE_PLOAD;
               pin_b = pout_a;
            end else if (op_r == OP_LOAD_A) begin
               s_a = MODE_PLOAD;
            end else begin
               s_a = MODE_HOLD;
            end
         end
         SHIFT: begin
            s_a     = MODE_SHR;
            s_b     = MODE_SHR;
            sin_r_b = sout_a;
            if (op_r == OP_SWAP) begin
               sin_r_a = sout_b;
            end else if (op_r == OP_MOVE_A2B) begin
`ifdef SR_CTRL_ROTATE_EN
               sin_r_a = sout_a;
`else
               sin_r_a = 1'b0;
`endif
            end else begin
               sin_r_a = 1'b0;
            end
            if (count_r == {CW{1'b0}}) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SHIFT;
            end
         end
         DONE: begin
            done         = 1'b1;
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sr_transfer_ctrl.sv
// Directed bench for sr_transfer_ctrl with behavioural models of the two
// controlled shift registers (shift right: serial_in_r enters at the MSB).
module tb_sr_transfer_ctrl;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          clear_b;
   logic          start;
   logic [1:0]    op;
   logic          sout_a, sout_b;
   logic [W-1:0]  pout_a;
   logic [1:0]    s_a, s_b;
   logic          sin_r_a, sin_r_b;
   logic [W-1:0]  pin_b;
   logic          busy, done;

   logic [W-1:0]  reg_a, reg_b, par_a;
   logic [11:0]   outs_s;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   sr_transfer_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .clear_b(clear_b), .start(start), .op(op),
      .sout_a(sout_a), .sout_b(sout_b), .pout_a(pout_a),
      .s_a(s_a), .s_b(s_b), .sin_r_a(sin_r_a), .sin_r_b(sin_r_b),
      .pin_b(pin_b), .busy(busy), .done(done)
   );

   assign sout_a = reg_a[0];
   assign sout_b = reg_b[0];
   assign pout_a = reg_a;
   assign outs_s = {busy, done, s_a, s_b, sin_r_a, sin_r_b, pin_b};

   // External shift registers A and B
   always_ff @(posedge clk or posedge clear_b) begin
      if (clear_b) begin
         reg_a <= '0;
         reg_b <= '0;
      end else begin
         case (s_a)
            2'b01:   reg_a <= {sin_r_a, reg_a[W-1:1]};
            2'b10:   reg_a <= {reg_a[W-2:0], 1'b0};
            2'b11:   reg_a <= par_a;
            default: reg_a <= reg_a;
         endcase
         case (s_b)
            2'b01:   reg_b <= {sin_r_b, reg_b[W-1:1]};
            2'b10:   reg_b <= {reg_b[W-2:0], 1'b0};
            2'b11:   reg_b <= pin_b;
            default: reg_b <= reg_b;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start one operation from IDLE and observe it to completion; optional
   // start pokes (op=00) at cycle indices poke1/poke2 while it is busy.
   task automatic run_op(input logic [1:0] opc, input int poke1, input int poke2,
                         output int busy_n, output int done_n, output int sa11_n,
                         output int sb11_n, output logic [W-1:0] pin_seen);
      bit fin = 1'b0;
      busy_n = 0; done_n = 0; sa11_n = 0; sb11_n = 0; pin_seen = '0;
      start = 1'b1;
      op    = opc;
      for (int k = 1; k <= 20 && !fin; k++) begin
         @(posedge clk); #1;
         if (busy) busy_n++;
         if (done) done_n++;
         if (s_a == 2'b11) sa11_n++;
         if (s_b == 2'b11) begin
            sb11_n++;
            pin_seen = pin_b;
         end
         start = (k == poke1) || (k == poke2);
         op    = start ? 2'b00 : ~opc;
         if (!busy) begin
            start = 1'b0;
            op    = 2'b00;
            fin   = 1'b1;
         end
      end
      if (!fin) begin
         check_eq("timeout", 32'd0, 32'd1);
         start = 1'b0;
      end
   endtask

   task automatic load_a(input logic [W-1:0] val);
      int bn, dn, sa, sb;
      logic [W-1:0] pv;
      par_a = val;
      run_op(2'b00, 0, 0, bn, dn, sa, sb, pv);
      check_eq("load_busy", bn, 2);
      check_eq("load_done", dn, 1);
      check_eq("load_a_val", reg_a, val);
   endtask

   initial begin
      int bn, dn, sa, sb, cnt;
      logic [W-1:0] pv;
      logic [8:0]   dv, bv;
      clear_b = 1'b1; start = 1'b0; op = 2'b00; par_a = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_outs", outs_s, 12'h000);
      clear_b = 1'b0;
      @(posedge clk); #1;
      check_eq("idle_outs", outs_s, 12'h000);

      // Reset in the middle of a shift
      load_a(4'b1011);
      start = 1'b1; op = 2'b01;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check_eq("mid_shift_mode", s_a, 2'b01);
      #2 clear_b = 1'b1;
      #1;
      check_eq("rst_async_outs", outs_s, 12'h000);
      @(posedge clk); #1;
      clear_b = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done || busy) cnt++;
      end
      check_eq("no_done_after_rst", cnt, 0);

      // MOVE_A2B, with op changed mid-operation
      load_a(4'b1011);
      run_op(2'b01, 0, 0, bn, dn, sa, sb, pv);
      check_eq("move_busy", bn, 5);
      check_eq("move_done", dn, 1);
      check_eq("move_b", reg_b, 4'b1011);
`ifdef SR_CTRL_ROTATE_EN
      check_eq("move_a", reg_a, 4'b1011);
`else
      check_eq("move_a", reg_a, 4'b0000);
`endif

      // SWAP: B=0110 via copy, A=1011
      load_a(4'b0110);
      run_op(2'b11, 0, 0, bn, dn, sa, sb, pv);
      check_eq("copy1_b", reg_b, 4'b0110);
      load_a(4'b1011);
      run_op(2'b10, 0, 0, bn, dn, sa, sb, pv);
      check_eq("swap_busy", bn, 5);
      check_eq("swap_done", dn, 1);
      check_eq("swap_a", reg_a, 4'b0110);
      check_eq("swap_b", reg_b, 4'b1011);

      // COPY_A2B
      load_a(4'b1001);
      run_op(2'b11, 0, 0, bn, dn, sa, sb, pv);
      check_eq("copy_busy", bn, 2);
      check_eq("copy_done", dn, 1);
      check_eq("copy_sb11", sb, 1);
      check_eq("copy_sa11", sa, 0);
      check_eq("copy_pin", pv, 4'b1001);
      check_eq("copy_b", reg_b, 4'b1001);

      // Starts during SHIFT (cycle 2) and DONE (cycle 5) are ignored
      par_a = 4'b1111;
      run_op(2'b01, 2, 5, bn, dn, sa, sb, pv);
      check_eq("ign_busy", bn, 5);
      check_eq("ign_done", dn, 1);
      check_eq("ign_no_load", sa, 0);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (busy) cnt++;
      end
      check_eq("ign_not_queued", cnt, 0);
      check_eq("ign_b", reg_b, 4'b1001);

      // Back-to-back LOAD_A with start held high
      par_a = 4'b0101;
      start = 1'b1; op = 2'b00;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         dv[k-1] = done;
         bv[k-1] = busy;
      end
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("b2b_done", dv, 9'b010010010);
      check_eq("b2b_busy", bv, 9'b011011011);
      check_eq("b2b_a", reg_a, 4'b0101);
      check_eq("final_idle", outs_s, 12'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
